adder_serial_nbit: RTL and testbench

- Parametrised multi-cycle N-bit adder; successor to the team's 1-bit full adder.
- Consumes CHUNK bits per clock: a ripple slice of CHUNK full-adder cells with a registered carry between chunks.
- Start/busy/done handshake; WIDTH/CHUNK cycles per operation.
- Used where area matters more than throughput, e.g. accumulators and checksum datapaths in later labs.

---
 rtl/adder_serial_nbit.sv | 156 +++++++++++++++
 tb/tb_adder_serial_nbit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_serial_nbit.sv
// Multi-cycle N-bit adder: CHUNK bits per clock through a ripple slice.
// Optional subtract mode via ADDER_SERIAL_SUB_EN (adds the sub port).
module adder_serial_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef ADDER_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             b_inv;
  logic             c0;
  logic [WIDTH-1:0] b_in;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic [CHUNK:0]   cc;
  logic [WIDTH-1:0] res_sh;
  logic             last;

`ifdef ADDER_SERIAL_SUB_EN
  // a - b as a + ~b + 1; carry_in is ignored while subtracting
  assign b_inv = sub;
  assign c0    = sub ? 1'b1 : carry_in;
`else
  assign b_inv = 1'b0;
  assign c0    = carry_in;
`endif

  assign b_in = b ^ {WIDTH{b_inv}};

  always_comb begin
    ca    = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    cb    = b_q[int'(cnt_q)*CHUNK +: CHUNK];
    cc    = '0;
    cs    = '0;
    cc[0] = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      cs[i]   = ca[i] ^ cb[i] ^ cc[i];
      cc[i+1] = (ca[i] & cb[i])
              | (cc[i] & (ca[i] ^ cb[i]));
    end
  end

  // Result enters at the top and shifts down one chunk per cycle
  generate
    if (CHUNK == WIDTH) begin : g_one
      assign res_sh = cs;
    end else begin : g_shift
      assign res_sh = {cs, res_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b_in;
          carry_d = c0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        res_d   = res_sh;
        carry_d = cc[CHUNK];
        if (last) begin
          sum_d   = res_sh;
          cout_d  = cc[CHUNK];
          ovf_d   = cc[CHUNK] ^ cc[CHUNK-1];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == ADD);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_serial_nbit.sv
// Scoreboard bench for adder_serial_nbit (WIDTH=16, CHUNK=4).
// Subtract cases run when ADDER_SERIAL_SUB_EN is defined.
module tb_adder_serial_nbit;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  typedef struct packed {
    logic         v;
    logic         c;
    logic [W-1:0] s;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  adder_serial_nbit #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (cin),
`ifdef ADDER_SERIAL_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (cout),
    .overflow  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic ci,
                                 input logic sb);
    exp_t       e;
    logic [W:0] t;
    logic [W-1:0] yy;
    logic       cc;
    yy  = sb ? ~y : y;
    cc  = sb ? 1'b1 : ci;
    t   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    e.s = t[W-1:0];
    e.c = t[W];
    e.v = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("extra_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
        chk("ovf", 32'(ovf), 32'(e.v));
      end
    end
  end

  task automatic drive(input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input logic ci,
                       input logic sb);
    a     = x;
    b     = y;
    cin   = ci;
    sub   = sb;
    start = 1'b1;
    q.push_back(model(x, y, ci, sb));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic issue(input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input logic ci,
                       input logic sb);
    @(negedge clk);
    drive(x, y, ci, sb);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("busy_hi", 32'(busy), 1);
      chk("done_lo", 32'(done), 0);
    end
    @(negedge clk);
    chk("done_hi", 32'(done), 1);
    chk("busy_lo", 32'(busy), 0);
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 1);
  endtask

  logic [W-1:0] prev;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // reset mid-operation: abort, no done pulse
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_pre_rst", 32'(busy), 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    chk("abort_ovf", 32'(ovf), 0);
    repeat (2 * N) @(negedge clk);

    issue(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    chk("hold_sum", 32'(sum), 32'h2345);
    chk("done_once", 32'(done), 0);

    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);

    // second start while busy must be ignored
    @(negedge clk);
    drive(16'h0F0F, 16'h1010, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (3 * N) @(negedge clk);
    chk("ign_q_empty", 32'(q.size()), 0);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    drive(16'h4321, 16'h0101, 1'b0, 1'b0);
    wait_done();
    prev = sum;
    drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("b2b_busy", 32'(busy), 1);
      chk("b2b_hold", 32'(sum), 32'h4422);
    end
    @(negedge clk);
    chk("b2b_done", 32'(done), 1);
    chk("b2b_sum", 32'(sum), 32'h0100);
    chk("b2b_prev", 32'(prev), 32'h4422);

    for (int k = 0; k < 6; k++) begin
      issue(W'($urandom), W'($urandom),
            1'($urandom), 1'b0);
    end
    issue(16'h8000, 16'h8000, 1'b0, 1'b0);

`ifdef ADDER_SERIAL_SUB_EN
    issue(16'h0005, 16'h0007, 1'b1, 1'b1);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    issue(16'h1234, 16'h1234, 1'b0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    chk("q_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
